// File: rtl/fetch_prefetch_pkg.sv
// Shared constants and width helpers for the prefetching fetch stage.
package fetch_prefetch_pkg;

    localparam int unsigned NOP_WIDTH = 32;
    localparam logic [NOP_WIDTH-1:0] NOP_WORD = 32'h0000_0000;

    // Bits needed for a counter that holds 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index depth entries.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO with flush; head word is visible combinationally, writes are registered.
module fetch_prefetch_fifo
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CW = cnt_width(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_rdata_c,
    output logic [CW-1:0]    o_count,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign o_full_c  = (count_q == CW'(DEPTH));
    assign o_empty_c = (count_q == '0);
    assign o_rdata_c = mem_q[rd_ptr_q];
    assign o_count   = count_q;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        do_push  = i_push && !o_full_c && !i_flush;
        do_pop   = i_pop && !o_empty_c && !i_flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Control state.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_wdata;
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: credit-based sequential prefetch into a FIFO, one instruction per cycle to decode.
module fetch_prefetch
    import fetch_prefetch_pkg::*;
#(
    parameter int unsigned INSTR_ADDR_WIDTH = 30,
    parameter int unsigned INSTR_WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter int unsigned MAX_OUTSTANDING  = 2,
    localparam int unsigned PC_WIDTH        = INSTR_ADDR_WIDTH - 2
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic                        i_jmp_en,
    input  logic [PC_WIDTH-1:0]         i_pc_jmp,
    input  logic                        i_fe_kill,
    input  logic                        i_stall_en,
    output logic                        o_imem_req,
    output logic [INSTR_ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                        i_imem_gnt,
    input  logic                        i_imem_rvalid,
    input  logic [INSTR_WIDTH-1:0]      i_imem_rdata,
    output logic [PC_WIDTH-1:0]         o_pc_fe,
    output logic [PC_WIDTH-1:0]         o_pc_fe_de,
    output logic [INSTR_WIDTH-1:0]      o_instruction,
    output logic                        o_valid
);

    localparam int unsigned OW = cnt_width(MAX_OUTSTANDING);
    localparam int unsigned FW = cnt_width(FIFO_DEPTH);
    localparam int unsigned SW = FW + 1;
    localparam int unsigned EW = PC_WIDTH + INSTR_WIDTH;

    logic [PC_WIDTH-1:0]    pc_fe_q, pc_fe_d;
    logic [PC_WIDTH-1:0]    pc_fe_de_q, pc_fe_de_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d;
    logic [OW-1:0]          outstanding_q, outstanding_d;
    logic [OW-1:0]          discard_q, discard_d;

    logic                   flush, credits_ok, imem_req_c, accept, resp, resp_keep, dq_pop;
    logic [PC_WIDTH-1:0]    pcq_head;
    logic [FW-1:0]          pcq_count, dq_count;
    logic                   pcq_full, pcq_empty, dq_full, dq_empty;
    logic [EW-1:0]          dq_head;
    logic                   unused_fifo_status;

    // PCs of accepted requests, matched in order against kept responses.
    fetch_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_pc_fifo (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_push    (accept),
        .i_wdata   (pc_fe_q),
        .i_pop     (resp_keep),
        .i_flush   (flush),
        .o_rdata_c (pcq_head),
        .o_count   (pcq_count),
        .o_full_c  (pcq_full),
        .o_empty_c (pcq_empty)
    );

    // Prefetch buffer of {pc, instruction} pairs awaiting decode.
    fetch_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_data_fifo (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .i_push    (resp_keep),
        .i_wdata   ({pcq_head, i_imem_rdata}),
        .i_pop     (dq_pop),
        .i_flush   (flush),
        .o_rdata_c (dq_head),
        .o_count   (dq_count),
        .o_full_c  (dq_full),
        .o_empty_c (dq_empty)
    );

    assign unused_fifo_status = ^{pcq_count, pcq_full, pcq_empty, dq_full};

    // Issue decision and handshake qualification; credits reserve FIFO space for every request in flight.
    always_comb begin
        flush      = i_jmp_en || i_fe_kill;
        credits_ok = (SW'(dq_count) + SW'(outstanding_q)) < SW'(FIFO_DEPTH);
        imem_req_c = !flush && (outstanding_q < OW'(MAX_OUTSTANDING)) && credits_ok;
        accept     = imem_req_c && i_imem_gnt;
        resp       = i_imem_rvalid && (outstanding_q != '0);
        resp_keep  = resp && (discard_q == '0) && !flush;
        dq_pop     = !flush && !i_stall_en && !dq_empty;
    end

    // Next-state for counters, fetch PC and the decode output register.
    always_comb begin
        outstanding_d = outstanding_q + OW'(accept) - OW'(resp);
        discard_d     = discard_q;
        pc_fe_d       = pc_fe_q;
        pc_fe_de_d    = pc_fe_de_q;
        instr_d       = instr_q;
        valid_d       = valid_q;

        if (flush) begin
            discard_d = outstanding_d;
        end else if (resp && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
        end

        if (i_jmp_en) begin
            pc_fe_d = i_pc_jmp;
        end else if (accept) begin
            pc_fe_d = pc_fe_q + PC_WIDTH'(1);
        end

        if (flush) begin
            instr_d = INSTR_WIDTH'(NOP_WORD);
            valid_d = 1'b0;
        end else if (!i_stall_en) begin
            if (!dq_empty) begin
                pc_fe_de_d = dq_head[EW-1 -: PC_WIDTH];
                instr_d    = dq_head[INSTR_WIDTH-1:0];
                valid_d    = 1'b1;
            end else begin
                instr_d = INSTR_WIDTH'(NOP_WORD);
                valid_d = 1'b0;
            end
        end
    end

    // State registers.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            pc_fe_q       <= '0;
            pc_fe_de_q    <= '0;
            instr_q       <= '0;
            valid_q       <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            pc_fe_q       <= pc_fe_d;
            pc_fe_de_q    <= pc_fe_de_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign o_imem_req    = imem_req_c;
    assign o_imem_addr   = {pc_fe_q, 2'b00};
    assign o_pc_fe       = pc_fe_q;
    assign o_pc_fe_de    = pc_fe_de_q;
    assign o_instruction = instr_q;
    assign o_valid       = valid_q;

    // A response with nothing outstanding is a memory-side protocol error.
    a_no_spurious_rvalid: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        i_imem_rvalid |-> (outstanding_q != '0));

    // A kept response always has a matching request PC.
    a_pc_available: assert property (@(posedge i_clk) disable iff (!i_arst_n)
        resp_keep |-> !pcq_empty);

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed and randomized checks of fetch_prefetch against an in-order memory model.
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rst_n, jmp, kill, stall;
    logic [27:0] pc_jmp;
    logic        req, gnt, rvalid, valid;
    logic [29:0] addr;
    logic [31:0] rdata, instr;
    logic [27:0] pc_fe, pc_fe_de;

    int n_cmp = 0;
    int n_err = 0;

    // Memory model state.
    typedef struct { int due; logic [29:0] addr; } req_t;
    req_t        mq[$];
    int          cyc = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    logic [27:0] exp_issue_pc = '0;
    int          addr_err = 0;
    int          max_q = 0;

    logic [27:0] exp_out;
    logic [27:0] kpc;
    bit          found;

    always #5 clk = ~clk;

    fetch_prefetch dut (
        .i_clk         (clk),
        .i_arst_n      (rst_n),
        .i_jmp_en      (jmp),
        .i_pc_jmp      (pc_jmp),
        .i_fe_kill     (kill),
        .i_stall_en    (stall),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .i_imem_gnt    (gnt),
        .i_imem_rvalid (rvalid),
        .i_imem_rdata  (rdata),
        .o_pc_fe       (pc_fe),
        .o_pc_fe_de    (pc_fe_de),
        .o_instruction (instr),
        .o_valid       (valid)
    );

    // Instruction memory: drives at negedge, samples the handshake just before posedge; data = byte address.
    initial begin
        gnt    = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) mq.delete();
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                rvalid = 1'b1;
                rdata  = 32'(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                rvalid = 1'b0;
                rdata  = 32'hDEAD_BEEF;
            end
            gnt = mem_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (!rst_n) begin
                exp_issue_pc = '0;
                mq.delete();
            end else if (jmp) begin
                exp_issue_pc = pc_jmp;
            end else if (req && gnt) begin
                if (addr !== {exp_issue_pc, 2'b00}) addr_err++;
                mq.push_back('{due: cyc + (mem_rand ? int'($urandom_range(1, 6)) : mem_lat), addr: addr});
                exp_issue_pc++;
                if (mq.size() > max_q) max_q = mq.size();
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the next valid output and check its PC and word.
    task automatic expect_next(input logic [27:0] pc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (valid === 1'b1) seen = 1'b1;
        end
        chk({tag, "_seen"}, 64'(seen), 64'h1);
        if (seen) begin
            chk({tag, "_pc"}, 64'(pc_fe_de), 64'(pc));
            chk({tag, "_instr"}, 64'(instr), 64'({pc, 2'b00}));
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        jmp    = 1'b0;
        kill   = 1'b0;
        stall  = 1'b0;
        pc_jmp = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_pc_fe", 64'(pc_fe), 64'h0);
        chk("rst_pc_de", 64'(pc_fe_de), 64'h0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_valid", 64'(valid), 64'h0);
        rst_n = 1'b1;

        // 1: back-to-back fetch, 1-cycle memory; first valid two edges after first accept
        @(negedge clk);
        chk("t1_valid_e1", 64'(valid), 64'h0);
        chk("t1_pc_fe_e1", 64'(pc_fe), 64'h1);
        @(negedge clk);
        chk("t1_valid_e2", 64'(valid), 64'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_valid", 64'(valid), 64'h1);
            chk("t1_pc_de", 64'(pc_fe_de), 64'(k));
            chk("t1_instr", 64'(instr), 64'(k * 4));
        end

        // 2: stall 10 cycles; prefetch fills exactly FIFO_DEPTH then stops requesting
        stall = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", 64'(valid), 64'h1);
            chk("t2_hold_pc_de", 64'(pc_fe_de), 64'h3);
            chk("t2_hold_instr", 64'(instr), 64'hC);
        end
        chk("t2_pc_fe", 64'(pc_fe), 64'h8);
        #1;
        chk("t2_req", 64'(req), 64'h0);
        stall = 1'b0;
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            chk("t2_rel_valid", 64'(valid), 64'h1);
            chk("t2_rel_pc_de", 64'(pc_fe_de), 64'(k));
            chk("t2_rel_instr", 64'(instr), 64'(k * 4));
        end

        // 3: jump with two requests in flight; their responses must be dropped
        mem_lat = 3;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            #1;
            if (mq.size() == 2 && rvalid === 1'b0) found = 1'b1;
        end
        chk("t3_two_inflight", 64'(found), 64'h1);
        jmp    = 1'b1;
        pc_jmp = 28'h100;
        @(negedge clk);
        jmp = 1'b0;
        chk("t3_flush_valid", 64'(valid), 64'h0);
        chk("t3_flush_instr", 64'(instr), 64'h0);
        chk("t3_pc_fe", 64'(pc_fe), 64'h100);
        expect_next(28'h100, "t3_first");
        expect_next(28'h101, "t3_second");

        // 4: kill for 5 cycles; no issue, no output, PC held, resume from same PC
        mem_lat = 2;
        repeat (3) @(negedge clk);
        kpc  = exp_issue_pc;
        kill = 1'b1;
        #1;
        chk("t4_req_first", 64'(req), 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_valid", 64'(valid), 64'h0);
            chk("t4_instr", 64'(instr), 64'h0);
            chk("t4_pc_fe", 64'(pc_fe), 64'(kpc));
            #1;
            chk("t4_req", 64'(req), 64'h0);
        end
        kill = 1'b0;
        expect_next(kpc, "t4_resume0");
        expect_next(kpc + 28'h1, "t4_resume1");

        // 5a: PC wrap from all-ones to zero
        mem_lat = 1;
        jmp     = 1'b1;
        pc_jmp  = 28'hFFF_FFFE;
        @(negedge clk);
        jmp = 1'b0;
        chk("t5_wrap_pc_fe", 64'(pc_fe), 64'hFFF_FFFE);
        expect_next(28'hFFF_FFFE, "t5_wrap_m2");
        expect_next(28'hFFF_FFFF, "t5_wrap_m1");
        expect_next(28'h000_0000, "t5_wrap_0");
        expect_next(28'h000_0001, "t5_wrap_1");

        // 5b: random grant/latency, stalls, jumps and kills against the reference PC stream
        exp_out  = 28'h2;
        mem_rand = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (jmp || kill) begin
                chk("t5_flush_valid", 64'(valid), 64'h0);
                exp_out = exp_issue_pc;
            end else if (!stall && valid === 1'b1) begin
                chk("t5_pc_de", 64'(pc_fe_de), 64'(exp_out));
                chk("t5_instr", 64'(instr), 64'({exp_out, 2'b00}));
                exp_out++;
            end
            chk("t5_pc_fe", 64'(pc_fe), 64'(exp_issue_pc));
            stall  = ($urandom_range(0, 4) == 0);
            jmp    = ($urandom_range(0, 49) == 0);
            kill   = !jmp && ($urandom_range(0, 59) == 0) || ($urandom_range(0, 299) == 0);
            pc_jmp = ($urandom_range(0, 1) == 1) ? 28'hFFF_FFFD : 28'($urandom);
        end
        stall    = 1'b0;
        jmp      = 1'b0;
        kill     = 1'b0;
        mem_rand = 1'b0;

        // 6: asynchronous reset mid-stream with responses pending
        mem_lat = 3;
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_pc_fe", 64'(pc_fe), 64'h0);
        chk("t6_pc_de", 64'(pc_fe_de), 64'h0);
        chk("t6_instr", 64'(instr), 64'h0);
        chk("t6_valid", 64'(valid), 64'h0);
        chk("t6_addr", 64'(addr), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_next(28'h0, "t6_restart0");
        expect_next(28'h1, "t6_restart1");
        expect_next(28'h2, "t6_restart2");

        // Request-side invariants seen by the memory model
        chk("addr_sequence_errors", 64'(addr_err), 64'h0);
        chk("max_outstanding_le_2", 64'(max_q <= 2), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
